norm_round: RTL and testbench

NORM_ROUND -- requirements
Module: norm_round

---
 rtl/norm_round.sv | 128 ++++++++++++
 tb/tb_norm_round.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/norm_round.sv
// Post-add normalize and round stage for single-precision addition.
// It takes a raw mantissa sum and produces an IEEE-754 result over a valid/ready handshake.
module norm_round #(
    parameter int SIZE_MAN = 28,
    parameter int SIZE_EXP = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SIZE_MAN-1:0] i_man,
    input  logic                i_overflow,
    input  logic [SIZE_EXP-1:0] i_exp,
    input  logic                i_sign,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [31:0]         o_result,
    output logic                o_overflow
);

    localparam int EXP_W = SIZE_EXP + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_OUT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SIZE_MAN-1:0] r_man;
    logic [EXP_W-1:0]    r_exp;
    logic                r_sign;
    logic [31:0]         r_result;
    logic                r_overflow;

    logic                w_accept;
    logic                w_zero;
    logic                w_norm_shift;
    logic                w_sticky;
    logic                w_inc;
    logic [24:0]         w_sum;
    logic                w_carry;
    logic [23:0]         w_mant;
    logic [EXP_W-1:0]    w_exp_rnd;
    logic                w_sat;
    logic [7:0]          w_exp_field;
    logic [31:0]         w_rounded;

    assign w_accept     = i_valid && (r_state == S_IDLE);
    assign w_zero       = !i_overflow && (i_man == '0);
    assign w_norm_shift = !r_man[SIZE_MAN-1] && (r_exp > EXP_W'(1));

    // Round to nearest even on the 24-bit significand M[27:4].
    assign w_sticky    = r_man[1] | r_man[0];
    assign w_inc       = r_man[3] & (r_man[2] | w_sticky | r_man[4]);
    assign w_sum       = {1'b0, r_man[SIZE_MAN-1:4]} + {24'd0, w_inc};
    assign w_carry     = w_sum[24];
    assign w_mant      = w_carry ? w_sum[24:1] : w_sum[23:0];
    assign w_exp_rnd   = r_exp + {{(EXP_W-1){1'b0}}, w_carry};
    assign w_sat       = w_exp_rnd >= EXP_W'(255);
    assign w_exp_field = w_mant[23] ? w_exp_rnd[7:0] : 8'd0;
    assign w_rounded   = w_sat ? {r_sign, 8'hFF, 23'd0}
                               : {r_sign, w_exp_field, w_mant[22:0]};

    always_comb begin
        // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_state_next = w_zero ? S_OUT : S_NORM;
            S_NORM:  if (!w_norm_shift) w_state_next = S_ROUND;
            S_ROUND: w_state_next = S_OUT;
            S_OUT:   if (i_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_man      <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= i_sign;
                        if (i_overflow) begin
                            // Sum >= 2.0: pre-shift right, folding the dropped bit into sticky.
                            r_man <= {1'b1, i_man[SIZE_MAN-1:2], i_man[1] | i_man[0]};
                            r_exp <= {2'b00, i_exp} + EXP_W'(1);
                        end else begin
                            r_man <= i_man;
                            r_exp <= {2'b00, i_exp};
                        end
                        if (w_zero) begin
                            r_result   <= '0;
                            r_overflow <= 1'b0;
                        end
                    end
                end
                S_NORM: begin
                    if (w_norm_shift) begin
                        r_man <= {r_man[SIZE_MAN-2:0], 1'b0};
                        r_exp <= r_exp - EXP_W'(1);
                    end
                end
                S_ROUND: begin
                    r_result   <= w_rounded;
                    r_overflow <= w_sat;
                end
                default: ;
            endcase
        end
    end

    assign o_ready    = (r_state == S_IDLE);
    assign o_valid    = (r_state == S_OUT);
    assign o_result   = r_result;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_norm_round.sv
// Directed bench for norm_round: the driver pushes expected results, and a monitor
// compares them, with output timing, on the first o_valid cycle of each result.
module tb_norm_round;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [27:0] i_man;
    logic        i_overflow;
    logic [7:0]  i_exp;
    logic        i_sign;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_overflow;

    norm_round dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_man      (i_man),
        .i_overflow (i_overflow),
        .i_exp      (i_exp),
        .i_sign     (i_sign),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        prev_v = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // The first cycle of each output carries the value and is timed against the accept edge.
    always @(negedge i_clk) begin
        if (o_valid && !prev_v) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", o_result, e.result);
                check("overflow", 32'(o_overflow), 32'(e.ovf));
                check("latency_cycle", cyc, e.due);
            end
        end
        prev_v = o_valid;
    end

    // Accept happens on the edge after the first negedge that sees o_ready; counting that
    // accept cycle as cycle 1, o_valid is first seen after edge (accept + lat - 1).
    task automatic send(input logic [27:0] man, input logic ovf, input logic [7:0] ex,
                        input logic sg, input logic [31:0] res, input logic rovf,
                        input int lat, input bit noise);
        int   n;
        exp_t e;
        @(negedge i_clk);
        i_man = man; i_overflow = ovf; i_exp = ex; i_sign = sg; i_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) check("accept_timeout", 32'(o_ready), 32'd1);
        e.result = res; e.ovf = rovf; e.due = cyc + 32'(lat);
        sb.push_back(e);
        @(negedge i_clk);
        if (noise) begin
            // Busy-state inputs that must be ignored.
            i_man = 28'hFFFFFFF; i_overflow = 1'b1; i_exp = 8'hFE; i_sign = 1'b1;
            repeat (2) @(negedge i_clk);
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("back_to_idle_ready", 32'(o_ready), 32'd1);
        check("back_to_idle_valid", 32'(o_valid), 32'd0);
    endtask

    task automatic txn(input logic [27:0] man, input logic ovf, input logic [7:0] ex,
                       input logic sg, input logic [31:0] res, input logic rovf, input int lat);
        send(man, ovf, ex, sg, res, rovf, lat, 1'b0);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        i_rst = 1'b1; i_valid = 1'b0; i_man = '0; i_overflow = 1'b0;
        i_exp = 8'd0; i_sign = 1'b0; i_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check("reset_ready", 32'(o_ready), 32'd1);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_result", o_result, 32'd0);
        check("reset_overflow", 32'(o_overflow), 32'd0);

        // 1.0 + 1.0, with ignored i_valid while busy
        send(28'h0000000, 1'b1, 8'd127, 1'b0, 32'h40000000, 1'b0, 3, 1'b1);
        wait_idle();
        // exact cancellation gives +0 regardless of sign
        txn(28'h0000000, 1'b0, 8'd127, 1'b1, 32'h00000000, 1'b0, 1);
        // renormalize by 4
        txn(28'h0800000, 1'b0, 8'd127, 1'b0, 32'h3D800000, 1'b0, 7);
        // rounding: tie to even both ways, above half, below half
        txn(28'h8000018, 1'b0, 8'd127, 1'b0, 32'h3F800002, 1'b0, 3);
        txn(28'h8000008, 1'b0, 8'd127, 1'b0, 32'h3F800000, 1'b0, 3);
        txn(28'h800000C, 1'b0, 8'd127, 1'b0, 32'h3F800001, 1'b0, 3);
        txn(28'h8000009, 1'b0, 8'd127, 1'b0, 32'h3F800001, 1'b0, 3);
        txn(28'h8000004, 1'b0, 8'd127, 1'b0, 32'h3F800000, 1'b0, 3);
        // carry-in pre-shift keeps sticky, no round-up
        txn(28'h0000003, 1'b1, 8'd127, 1'b0, 32'h40000000, 1'b0, 3);
        // saturation via rounding carry, and via exponent increment alone
        txn(28'hFFFFFFF, 1'b1, 8'd254, 1'b1, 32'hFF800000, 1'b1, 3);
        txn(28'h0000000, 1'b1, 8'd254, 1'b0, 32'h7F800000, 1'b1, 3);
        txn(28'h8000000, 1'b0, 8'd255, 1'b0, 32'h7F800000, 1'b1, 3);
        // subnormal: normalization stops at E=1
        txn(28'h0000010, 1'b0, 8'd3, 1'b0, 32'h00000004, 1'b0, 5);
        // subnormal rounding into the hidden bit encodes exponent 1
        txn(28'h7FFFFF8, 1'b0, 8'd1, 1'b0, 32'h00800000, 1'b0, 3);
        txn(28'hC000000, 1'b0, 8'd130, 1'b1, 32'hC1400000, 1'b0, 3);

        // backpressure: hold the result for 5 cycles
        i_ready = 1'b0;
        send(28'hA000000, 1'b0, 8'd100, 1'b0, 32'h32200000, 1'b0, 3, 1'b0);
        n = 0;
        while (!o_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_result", o_result, 32'h32200000);
            check("hold_ready", 32'(o_ready), 32'd0);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        wait_idle();

        // reset mid-NORM (23 shifts pending)
        @(negedge i_clk);
        i_man = 28'h0000010; i_overflow = 1'b0; i_exp = 8'd127; i_sign = 1'b0; i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("busy_in_norm", 32'(o_ready), 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midnorm_rst_ready", 32'(o_ready), 32'd1);
        check("midnorm_rst_valid", 32'(o_valid), 32'd0);
        check("midnorm_rst_result", o_result, 32'd0);
        check("midnorm_rst_ovf", 32'(o_overflow), 32'd0);

        // reset wins over accept
        i_man = 28'h8000000; i_exp = 8'd127; i_valid = 1'b1; i_rst = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0; i_rst = 1'b0;
        check("rst_over_accept", 32'(o_ready), 32'd1);
        repeat (4) @(negedge i_clk);
        check("no_output_after_rst", 32'(o_valid), 32'd0);

        txn(28'h8000018, 1'b0, 8'd127, 1'b0, 32'h3F800002, 1'b0, 3);

        repeat (5) @(negedge i_clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
